// File: rtl/bus_control_sequencer.sv
// Control sequencer for a simple bus-based CPU datapath.
// Moore machine: every control output is decoded from the state register and
// the opcode field ir[31:27]; only state and the illegal-opcode flag are stored.
module bus_control_sequencer (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] ir,
  input  logic        mem_ready,
  output logic        PCout,
  output logic        PCin,
  output logic        IncPC,
  output logic        MARin,
  output logic        MDRin,
  output logic        MDRout,
  output logic        Read,
  output logic        Write,
  output logic        IRin,
  output logic        Yin,
  output logic        Zin,
  output logic        Zlowout,
  output logic        Cout,
  output logic        Gra,
  output logic        Grb,
  output logic        Grc,
  output logic        Rin,
  output logic        Rout,
  output logic        BAout,
  output logic [3:0]  alu_op,
  output logic        run,
  output logic        illegal_op
);

  typedef enum logic [3:0] {
    StRst, StT0, StT1, StT2, StT3, StT4, StT5, StT6, StT7, StHalt
  } state_e;

  localparam logic [3:0] AluAdd = 4'b0000;
  localparam logic [3:0] AluAnd = 4'b0010;
  localparam logic [3:0] AluOr  = 4'b0011;

  state_e state_q, state_d;
  logic   illegal_q, illegal_d;

  logic [4:0] op;
  logic       is_rr, is_imm, is_ld, is_st, is_nop, is_halt, is_legal;

  // Operand fields live in the datapath; only the opcode matters here.
  logic unused_ir;
  assign unused_ir = ^ir[26:0];

  assign op       = ir[31:27];
  assign is_rr    = (op[4:2] == 3'b000);
  assign is_imm   = (op == 5'b00100) || (op == 5'b00101) || (op == 5'b00110);
  assign is_ld    = (op == 5'b00111);
  assign is_st    = (op == 5'b01000);
  assign is_nop   = (op == 5'b11010);
  assign is_halt  = (op == 5'b11011);
  assign is_legal = is_rr || is_imm || is_ld || is_st || is_nop || is_halt;

  // Next-state selection; memory waits hold in T1, ld-T6 and st-T7 only.
  always_comb begin
    state_d   = state_q;
    illegal_d = 1'b0;
    unique case (state_q)
      StRst:  state_d = StT0;
      StT0:   state_d = StT1;
      StT1:   state_d = mem_ready ? StT2 : StT1;
      StT2: begin
        if (is_halt) begin
          state_d = StHalt;
        end else if (is_rr || is_imm || is_ld || is_st) begin
          state_d = StT3;
        end else begin
          state_d   = StT0;
          illegal_d = !is_legal;
        end
      end
      StT3:   state_d = StT4;
      StT4:   state_d = StT5;
      StT5:   state_d = (is_ld || is_st) ? StT6 : StT0;
      StT6: begin
        if (is_ld)      state_d = mem_ready ? StT7 : StT6;
        else if (is_st) state_d = StT7;
        else            state_d = StT0;
      end
      StT7: begin
        if (is_st) state_d = mem_ready ? StT0 : StT7;
        else       state_d = StT0;
      end
      StHalt: state_d = StHalt;
      default: state_d = StRst;
    endcase
  end

  // State register with synchronous reset that overrides any wait or HALT.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= StRst;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
    end
  end

  // Output decode; anything not listed for a state/opcode stays 0.
  always_comb begin
    {PCout, PCin, IncPC, MARin, MDRin, MDRout, Read, Write, IRin} = '0;
    {Yin, Zin, Zlowout, Cout, Gra, Grb, Grc, Rin, Rout, BAout}    = '0;
    alu_op     = AluAdd;
    run        = (state_q != StHalt);
    // illegal_q is only ever set on the T2->T0 edge, so this is T0's first cycle.
    illegal_op = illegal_q && (state_q == StT0);
    unique case (state_q)
      StT0: {PCout, MARin, IncPC, Zin} = '1;
      StT1: {Zlowout, PCin, Read, MDRin} = '1;
      StT2: {MDRout, IRin} = '1;
      StT3: begin
        if (is_rr || is_imm) {Grb, Rout, Yin} = '1;
        else if (is_ld || is_st) {Grb, BAout, Yin} = '1;
      end
      StT4: begin
        if (is_rr) begin
          {Grc, Rout, Zin} = '1;
          alu_op = {2'b00, op[1:0]};
        end else if (is_imm) begin
          {Cout, Zin} = '1;
          alu_op = (op == 5'b00101) ? AluAnd : (op == 5'b00110) ? AluOr : AluAdd;
        end else if (is_ld || is_st) begin
          {Cout, Zin} = '1;
        end
      end
      StT5: begin
        if (is_rr || is_imm) {Zlowout, Gra, Rin} = '1;
        else if (is_ld || is_st) {Zlowout, MARin} = '1;
      end
      StT6: begin
        if (is_ld) {Read, MDRin} = '1;
        else if (is_st) {Gra, Rout, MDRin} = '1;
      end
      StT7: begin
        if (is_ld) {MDRout, Gra, Rin} = '1;
        else if (is_st) Write = 1'b1;
      end
      default: ;
    endcase
  end

endmodule
